// File: rtl/vga_segdac_driver.sv
// vga_segdac_driver: VGA raster timing with thermometer-coded segmented DAC colour outputs.
module vga_segdac_driver #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pattern_en,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        visible,
    output logic [11:0] R,
    output logic [11:0] G,
    output logic [11:0] B,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);
    localparam logic [9:0] HV  = 10'(H_VIS);
    localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] HT1 = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VV  = 10'(V_VIS);
    localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] VT1 = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [11:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, fs_q, fs_d;
    logic        h_end, v_end;

    // Each 2-bit digit becomes a 3-bit thermometer code: 0->000, 1->001, 2->011, 3->111.
    function automatic logic [11:0] enc(input logic [7:0] c);
        logic [11:0] e;
        for (int k = 0; k < 4; k++)
            e[3*k +: 3] = {c[2*k+1] & c[2*k], c[2*k+1], c[2*k+1] | c[2*k]};
        return e;
    endfunction

    always_comb begin
        h_end   = hpos_q == HT1;
        v_end   = vpos_q == VT1;
        hpos_d  = h_end ? 10'd0 : hpos_q + 10'd1;
        vpos_d  = h_end ? (v_end ? 10'd0 : vpos_q + 10'd1) : vpos_q;
        fcnt_d  = (h_end && v_end) ? fcnt_q + 8'd1 : fcnt_q;
        visible = (hpos_q < HV) && (vpos_q < VV);
        r_d     = visible ? enc(pattern_en ? hpos_q[7:0] : pix_r) : 12'h000;
        g_d     = visible ? enc(pattern_en ? vpos_q[7:0] : pix_g) : 12'h000;
        b_d     = visible ? enc(pattern_en ? fcnt_q : pix_b) : 12'h000;
        hs_d    = !((hpos_q >= HS0) && (hpos_q < HS1));
        vs_d    = !((vpos_q >= VS0) && (vpos_q < VS1));
        fs_d    = (hpos_q == 10'd0) && (vpos_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q <= '0;
            vpos_q <= '0;
            fcnt_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            fcnt_q <= fcnt_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= visible;
            fs_q   <= fs_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
endmodule
